// File: rtl/ctrl_conv_output_mf_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_conv_output_mf_if : control/stream bus of the conv output sequencer
// rev 1.0
// ----------------------------------------------------------------------------
interface ctrl_conv_output_mf_if #(
   parameter int X_MEM_ADDR_WIDTH = 3,
   parameter int F_MEM_ADDR_WIDTH = 2,
   parameter int FSEL_WIDTH       = 1
);
   logic                        conv_start;
   logic                        m_ready_y;
   logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr;
   logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr;
   logic [FSEL_WIDTH-1:0]       fsel;
   logic                        mem_rd_en;
   logic                        accum_load;
   logic                        en_accum;
   logic                        m_valid_y;
   logic                        m_last_y;
   logic [FSEL_WIDTH-1:0]       y_filt_idx;
   logic                        conv_done;

   modport master (
      input  conv_start, m_ready_y,
      output xmem_addr, fmem_addr, fsel, mem_rd_en, accum_load, en_accum,
             m_valid_y, m_last_y, y_filt_idx, conv_done
   );

   modport slave (
      output conv_start, m_ready_y,
      input  xmem_addr, fmem_addr, fsel, mem_rd_en, accum_load, en_accum,
             m_valid_y, m_last_y, y_filt_idx, conv_done
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_conv_output_mf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_conv_output_mf : multi-filter, strided 1-D convolution output sequencer
// rev 1.0
// ----------------------------------------------------------------------------
module ctrl_conv_output_mf #(
   parameter int X_MEM_SIZE       = 8,
   parameter int F_MEM_SIZE       = 4,
   parameter int NUM_FILT         = 2,
   parameter int STRIDE           = 1,
   parameter int X_MEM_ADDR_WIDTH = 3,
   parameter int F_MEM_ADDR_WIDTH = 2,
   parameter int FSEL_WIDTH       = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   ctrl_conv_output_mf_if.master bus
);
   localparam int N_POS = (X_MEM_SIZE - F_MEM_SIZE) / STRIDE + 1;
   localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;

   localparam logic [POS_W-1:0]            C_POS_LAST  = POS_W'(N_POS - 1);
   localparam logic [F_MEM_ADDR_WIDTH-1:0] C_TAP_LAST  = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
   localparam logic [FSEL_WIDTH-1:0]       C_FILT_LAST = FSEL_WIDTH'(NUM_FILT - 1);
   localparam logic [X_MEM_ADDR_WIDTH-1:0] C_STRIDE    = X_MEM_ADDR_WIDTH'(STRIDE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_OUTPUT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                      state_q, state_d;
   logic [POS_W-1:0]            pos_q, pos_d;
   logic [X_MEM_ADDR_WIDTH-1:0] xbase_q, xbase_d;
   logic [F_MEM_ADDR_WIDTH-1:0] tap_q, tap_d;
   logic [FSEL_WIDTH-1:0]       filt_q, filt_d;
   logic                        start_prev_q;
   logic                        accum_load_q, accum_load_d;
   logic                        en_accum_q, en_accum_d;

   logic w_start_edge;
   logic w_abort;
   logic w_last_word;
   logic w_fetch;
   logic w_output;

   assign w_start_edge = bus.conv_start & ~start_prev_q;
   assign w_abort      = ~bus.conv_start &
                         ((state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_OUTPUT));
   assign w_last_word  = (pos_q == C_POS_LAST) && (filt_q == C_FILT_LAST);
   assign w_fetch      = (state_q == S_FETCH);
   assign w_output     = (state_q == S_OUTPUT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pos_q        <= '0;
         xbase_q      <= '0;
         tap_q        <= '0;
         filt_q       <= '0;
         start_prev_q <= 1'b0;
         accum_load_q <= 1'b0;
         en_accum_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         xbase_q      <= xbase_d;
         tap_q        <= tap_d;
         filt_q       <= filt_d;
         start_prev_q <= bus.conv_start;
         accum_load_q <= accum_load_d;
         en_accum_q   <= en_accum_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      xbase_d      = xbase_q;
      tap_d        = tap_q;
      filt_d       = filt_q;
      accum_load_d = 1'b0;
      en_accum_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_start_edge) begin
               state_d = S_FETCH;
               pos_d   = '0;
               xbase_d = '0;
               tap_d   = '0;
               filt_d  = '0;
            end
         end
         S_FETCH: begin
            // MAC strobes trail the read by the one-cycle memory latency
            accum_load_d = (tap_q == '0);
            en_accum_d   = (tap_q != '0);
            if (tap_q == C_TAP_LAST) begin
               state_d = S_WAIT;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         S_WAIT: begin
            state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (bus.m_ready_y) begin
               if (w_last_word) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
                  tap_d   = '0;
                  if (filt_q == C_FILT_LAST) begin
                     filt_d  = '0;
                     pos_d   = pos_q + 1'b1;
                     xbase_d = xbase_q + C_STRIDE;
                  end else begin
                     filt_d = filt_q + 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Dropping conv_start mid-run discards the word, including any MAC strobe in flight
      if (w_abort) begin
         state_d      = S_IDLE;
         accum_load_d = 1'b0;
         en_accum_d   = 1'b0;
      end
   end

   assign bus.mem_rd_en  = w_fetch;
   assign bus.xmem_addr  = w_fetch ? (xbase_q + X_MEM_ADDR_WIDTH'(tap_q)) : '0;
   assign bus.fmem_addr  = w_fetch ? tap_q : '0;
   assign bus.fsel       = w_fetch ? filt_q : '0;
   assign bus.accum_load = accum_load_q;
   assign bus.en_accum   = en_accum_q;
   assign bus.m_valid_y  = w_output;
   assign bus.m_last_y   = w_output & w_last_word;
   assign bus.y_filt_idx = w_output ? filt_q : '0;
   assign bus.conv_done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_conv_output_mf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ctrl_conv_output_mf : directed bench for three parameterisations of the sequencer
// rev 1.0
// ----------------------------------------------------------------------------
module tb_ctrl_conv_output_mf;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   sel   = 0;
   int   cur_f = 4;

   always #5 clk = ~clk;

   ctrl_conv_output_mf_if #(.X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(1)) bus_a ();
   ctrl_conv_output_mf_if #(.X_MEM_ADDR_WIDTH(4), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(1)) bus_b ();
   ctrl_conv_output_mf_if #(.X_MEM_ADDR_WIDTH(2), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(2)) bus_c ();

   ctrl_conv_output_mf #(
      .X_MEM_SIZE(8), .F_MEM_SIZE(4), .NUM_FILT(2), .STRIDE(1),
      .X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(1)
   ) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));

   ctrl_conv_output_mf #(
      .X_MEM_SIZE(9), .F_MEM_SIZE(3), .NUM_FILT(1), .STRIDE(2),
      .X_MEM_ADDR_WIDTH(4), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(1)
   ) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   ctrl_conv_output_mf #(
      .X_MEM_SIZE(4), .F_MEM_SIZE(4), .NUM_FILT(3), .STRIDE(1),
      .X_MEM_ADDR_WIDTH(2), .F_MEM_ADDR_WIDTH(2), .FSEL_WIDTH(2)
   ) u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
      end
   endtask

   // {rd, xaddr[7:0], faddr[3:0], fsel[3:0], accum_load, en_accum, valid, last, fidx[3:0], done}
   function automatic logic [31:0] pack(input int rd, input int x, input int f, input int fs,
                                        input int al, input int ea, input int v, input int l,
                                        input int fi, input int dn);
      return {6'd0, rd[0], x[7:0], f[3:0], fs[3:0], al[0], ea[0], v[0], l[0], fi[3:0], dn[0]};
   endfunction

   function automatic logic [31:0] obs();
      case (sel)
         0: return {6'd0, bus_a.mem_rd_en, 8'(bus_a.xmem_addr), 4'(bus_a.fmem_addr), 4'(bus_a.fsel),
                    bus_a.accum_load, bus_a.en_accum, bus_a.m_valid_y, bus_a.m_last_y,
                    4'(bus_a.y_filt_idx), bus_a.conv_done};
         1: return {6'd0, bus_b.mem_rd_en, 8'(bus_b.xmem_addr), 4'(bus_b.fmem_addr), 4'(bus_b.fsel),
                    bus_b.accum_load, bus_b.en_accum, bus_b.m_valid_y, bus_b.m_last_y,
                    4'(bus_b.y_filt_idx), bus_b.conv_done};
         default: return {6'd0, bus_c.mem_rd_en, 8'(bus_c.xmem_addr), 4'(bus_c.fmem_addr), 4'(bus_c.fsel),
                    bus_c.accum_load, bus_c.en_accum, bus_c.m_valid_y, bus_c.m_last_y,
                    4'(bus_c.y_filt_idx), bus_c.conv_done};
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      case (sel)
         0:       bus_a.conv_start = v;
         1:       bus_b.conv_start = v;
         default: bus_c.conv_start = v;
      endcase
   endtask

   task automatic set_ready(input logic v);
      bus_a.m_ready_y = v;
      bus_b.m_ready_y = v;
      bus_c.m_ready_y = v;
   endtask

   // Entered at the first FETCH cycle of a word; leaves one cycle after the handshake.
   task automatic word_check(input int base, input int filt, input int last,
                             input int hold, input bit rst_out);
      for (int t = 0; t < cur_f; t++) begin
         check_val("fetch", obs(), pack(1, base + t, t, filt, (t == 1) ? 1 : 0, (t >= 2) ? 1 : 0,
                                        0, 0, 0, 0));
         tick;
      end
      check_val("wait", obs(), pack(0, 0, 0, 0, (cur_f == 1) ? 1 : 0, (cur_f > 1) ? 1 : 0,
                                    0, 0, 0, 0));
      tick;
      check_val("output", obs(), pack(0, 0, 0, 0, 0, 0, 1, last, filt, 0));
      if (rst_out) begin
         reset = 1'b1;
         tick;
         check_val("rst_mid", obs(), 32'd0);
         reset = 1'b0;
         return;
      end
      if (hold > 0) begin
         set_ready(1'b0);
         for (int h = 0; h < hold; h++) begin
            tick;
            check_val("hold", obs(), pack(0, 0, 0, 0, 0, 0, 1, last, filt, 0));
         end
         set_ready(1'b1);
      end
      tick;
   endtask

   task automatic done_check;
      check_val("done", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick;
      check_val("idle", obs(), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus_a.conv_start = 1'b0;
      bus_b.conv_start = 1'b0;
      bus_c.conv_start = 1'b0;
      set_ready(1'b1);
      repeat (2) tick;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         check_val("reset", obs(), 32'd0);
      end
      reset = 1'b0;
      tick;

      // Defaults: 5 positions x 2 filters, ready held high
      sel   = 0;
      cur_f = 4;
      set_start(1'b1);
      tick;
      for (int w = 0; w < 10; w++) word_check(w / 2, w % 2, (w == 9) ? 1 : 0, 0, 1'b0);
      done_check();
      tick;
      check_val("no_rerun", obs(), 32'd0);

      // Backpressure on the fourth word
      set_start(1'b0);
      tick;
      set_start(1'b1);
      tick;
      for (int w = 0; w < 10; w++) word_check(w / 2, w % 2, (w == 9) ? 1 : 0, (w == 3) ? 7 : 0, 1'b0);
      done_check();

      // Abort during the third word's FETCH, then restart from position 0
      set_start(1'b0);
      tick;
      set_start(1'b1);
      tick;
      word_check(0, 0, 0, 0, 1'b0);
      word_check(0, 1, 0, 0, 1'b0);
      check_val("ab_tap0", obs(), pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tick;
      check_val("ab_tap1", obs(), pack(1, 2, 1, 0, 1, 0, 0, 0, 0, 0));
      set_start(1'b0);
      tick;
      check_val("abort", obs(), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check_val("no_done", obs(), 32'd0);
      end
      set_start(1'b1);
      tick;
      word_check(0, 0, 0, 0, 1'b0);

      // Reset while presenting a word with ready high; start stays high so it re-arms
      word_check(0, 1, 0, 0, 1'b1);
      tick;
      word_check(0, 0, 0, 0, 1'b0);
      set_start(1'b0);
      tick;
      check_val("post_rst", obs(), 32'd0);

      // STRIDE=2, X=9, F=3, one filter: bases 0,2,4,6
      sel   = 1;
      cur_f = 3;
      set_start(1'b1);
      tick;
      for (int w = 0; w < 4; w++) word_check(2 * w, 0, (w == 3) ? 1 : 0, 0, 1'b0);
      done_check();
      set_start(1'b0);

      // X=F=4, three filters: single position, last on filter 2
      sel   = 2;
      cur_f = 4;
      set_start(1'b1);
      tick;
      for (int w = 0; w < 3; w++) word_check(0, w, (w == 2) ? 1 : 0, 0, 1'b0);
      done_check();
      set_start(1'b0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
